// File: rtl/layer_sequencer.sv
// layer_sequencer: steps cnn_layer through NUM_CONV conv layers and one affine layer, ping-ponging results.
// Define LAYER_SEQ_TIMEOUT_EN to add a per-layer watchdog that sets the sticky err flag.
module layer_sequencer #(
    parameter int unsigned NUM_CONV    = 4,
    parameter logic [3:0]  CONV_BASE   = 4'd1,
    parameter logic [3:0]  AFFINE_CODE = 4'd15,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       abort,
    input  logic       layer_valid,
    output logic       load,
    output logic [3:0] cs_layer,
    output logic       buf_we,
    output logic       buf_sel,
    output logic [3:0] layer_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, STORE, NEXT, DONE} state_t;

    state_t     state, state_nx;
    logic       valid_d, completion, timed_out;
    logic [3:0] idx_nx;

    if (NUM_CONV == 0 || NUM_CONV > 14 || 32'(CONV_BASE) + NUM_CONV > 16 || TIMEOUT < 2 ||
        (AFFINE_CODE >= CONV_BASE && 32'(AFFINE_CODE) < 32'(CONV_BASE) + NUM_CONV)) begin : g_bad_params
        $error("layer_sequencer: invalid parameter combination");
    end

    assign idx_nx     = layer_idx + 4'd1;
    assign completion = state == WAIT && layer_valid && !valid_d;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run ? LOAD : IDLE;
            LOAD:    state_nx = WAIT;
            WAIT:    state_nx = completion ? STORE : timed_out ? DONE : WAIT;
            STORE:   state_nx = layer_idx == 4'(NUM_CONV) ? DONE : NEXT;
            NEXT:    state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Outputs are registered from the next state so each one is valid for the whole state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            load      <= 1'b0;
            buf_we    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            valid_d   <= 1'b1;
            cs_layer  <= 4'd0;
            layer_idx <= 4'd0;
            buf_sel   <= 1'b0;
        end else begin
            state   <= state_nx;
            load    <= state_nx == LOAD;
            buf_we  <= state_nx == STORE;
            done    <= state_nx == DONE;
            busy    <= state_nx != IDLE;
            // A valid still high from the previous layer must fall and rise again to count.
            valid_d <= state == LOAD || layer_valid;
            if (state == IDLE && state_nx == LOAD) begin
                layer_idx <= 4'd0;
                cs_layer  <= CONV_BASE;
                buf_sel   <= 1'b0;
            end else if (state == NEXT && state_nx == LOAD) begin
                layer_idx <= idx_nx;
                buf_sel   <= ~buf_sel;
                cs_layer  <= idx_nx == 4'(NUM_CONV) ? AFFINE_CODE : CONV_BASE + idx_nx;
            end
        end
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT);

    logic [WW-1:0] wd_cnt;

    assign timed_out = state == WAIT && wd_cnt == WW'(TIMEOUT - 1) && !completion;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= state == LOAD ? '0 : state == WAIT ? wd_cnt + 1'b1 : wd_cnt;
            if (state == IDLE && state_nx == LOAD) err <= 1'b0;
            else if (timed_out && !abort) err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif
endmodule
